// File: rtl/game_pkg.sv
// Shared goose-run game definitions: state encoding, speed width and the
// default game-rate periods used by the sprite, obstacle and score blocks.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int SPEED_W             = 3;
    localparam int LEG_DIV_DEF         = 16;
    localparam int SCORE_DIV_DEF       = 256;
    localparam int SCROLL_DIV_INIT_DEF = 64;
    localparam int SCROLL_DIV_MIN_DEF  = 16;
    localparam int SCROLL_STEP_DEF     = 8;
    localparam int LEVEL_SCORE_DEF     = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Gated modulo-P counter producing a wrap strobe; a new period is only
// adopted at a wrap or a clear, so an interval in progress is never cut short.
module tick_divider #(
    parameter int CNT_W       = 8,
    parameter int PER_W       = 9,
    parameter int INIT_PERIOD = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PER_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_r;
    logic [PER_W-1:0] active_r;
    logic [PER_W-1:0] cnt_ext_s;
    logic             wrap_s;

    assign cnt_ext_s = PER_W'(cnt_r);
    assign wrap_s    = en && (cnt_ext_s == (active_r - PER_W'(1)));
    assign tick      = wrap_s;

    // Count register and active-period latch.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= PER_W'(INIT_PERIOD);
        end else if (clr) begin
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= period;
        end else if (wrap_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= period;
        end else if (en) begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r    <= cnt_r;
        end
    end

endmodule

// File: rtl/game_tick_scheduler.sv
// Game-loop timing controller: game FSM, leg/scroll/score tick enables and
// score-driven scroll speed-up.
module game_tick_scheduler
    import game_pkg::*;
#(
    parameter int LEG_DIV         = LEG_DIV_DEF,
    parameter int SCORE_DIV       = SCORE_DIV_DEF,
    parameter int SCROLL_DIV_INIT = SCROLL_DIV_INIT_DEF,
    parameter int SCROLL_DIV_MIN  = SCROLL_DIV_MIN_DEF,
    parameter int SCROLL_STEP     = SCROLL_STEP_DEF,
    parameter int LEVEL_SCORE     = LEVEL_SCORE_DEF
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               start_in,
    input  logic               pause_in,
    input  logic               collide_in,
    output logic               leg_tick,
    output logic               scroll_tick,
    output logic               score_tick,
    output logic [SPEED_W-1:0] speed_level,
    output logic [1:0]         game_state
);

    localparam int MAX_DIV = max3(LEG_DIV, SCORE_DIV, SCROLL_DIV_INIT);
    localparam int CNT_W   = $clog2(MAX_DIV);
    localparam int PER_W   = $clog2(MAX_DIV + 1);
    localparam int LVL_W   = $clog2(LEVEL_SCORE + 1);

    game_state_t      state_r, state_n_s;
    logic             stay_run_s, run_s, clr_s, can_step_s;
    logic             leg_wrap_s, scroll_wrap_s, score_wrap_s;
    logic [PER_W-1:0] pending_r;
    logic [LVL_W-1:0] lvl_cnt_r;

    // Game state register.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic; collision outranks pause while running.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE:  if (start_in) state_n_s = ST_RUN; else state_n_s = ST_IDLE;
            ST_RUN: begin
                if (collide_in)    state_n_s = ST_OVER;
                else if (pause_in) state_n_s = ST_PAUSE;
                else               state_n_s = ST_RUN;
            end
            ST_PAUSE: if (pause_in) state_n_s = ST_RUN; else state_n_s = ST_PAUSE;
            ST_OVER:  if (start_in) state_n_s = ST_RUN; else state_n_s = ST_OVER;
            default:  state_n_s = ST_IDLE;
        endcase
    end

    // Counters advance even on the edge that leaves RUN so a pause shifts ticks
    // by exactly its length; the tick itself is dropped on that edge.
    assign run_s      = (state_r == ST_RUN);
    assign stay_run_s = run_s && (state_n_s == ST_RUN);
    assign clr_s      = (state_r == ST_IDLE) || (state_r == ST_OVER) ||
                        (state_n_s == ST_IDLE) || (state_n_s == ST_OVER);
    assign game_state = state_r;

    tick_divider #(.CNT_W(CNT_W), .PER_W(PER_W), .INIT_PERIOD(LEG_DIV)) leg_u (
        .clk_in(clk_in), .rst_n(rst_n), .en(run_s), .clr(clr_s),
        .period(PER_W'(LEG_DIV)), .tick(leg_wrap_s)
    );

    tick_divider #(.CNT_W(CNT_W), .PER_W(PER_W), .INIT_PERIOD(SCROLL_DIV_INIT)) scroll_u (
        .clk_in(clk_in), .rst_n(rst_n), .en(run_s), .clr(clr_s),
        .period(pending_r), .tick(scroll_wrap_s)
    );

    tick_divider #(.CNT_W(CNT_W), .PER_W(PER_W), .INIT_PERIOD(SCORE_DIV)) score_u (
        .clk_in(clk_in), .rst_n(rst_n), .en(run_s), .clr(clr_s),
        .period(PER_W'(SCORE_DIV)), .tick(score_wrap_s)
    );

    // Registered tick enables.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            leg_tick    <= 1'b0;
            scroll_tick <= 1'b0;
            score_tick  <= 1'b0;
        end else begin
            leg_tick    <= leg_wrap_s && stay_run_s;
            scroll_tick <= scroll_wrap_s && stay_run_s;
            score_tick  <= score_wrap_s && stay_run_s;
        end
    end

    // Level-up allowed only while the shortened period stays at or above the floor.
    always_comb begin
        can_step_s = 1'b0;
        if ((int'(pending_r) >= SCROLL_DIV_MIN + SCROLL_STEP) &&
            (speed_level != {SPEED_W{1'b1}})) begin
            can_step_s = 1'b1;
        end else begin
            can_step_s = 1'b0;
        end
    end

    // Score-tick counting and speed-level / pending scroll period update.
    always_ff @(posedge clk_in) begin
        if (!rst_n || clr_s) begin
            lvl_cnt_r   <= {LVL_W{1'b0}};
            pending_r   <= PER_W'(SCROLL_DIV_INIT);
            speed_level <= {SPEED_W{1'b0}};
        end else if (score_tick) begin
            if (lvl_cnt_r == LVL_W'(LEVEL_SCORE - 1)) begin
                lvl_cnt_r <= {LVL_W{1'b0}};
                if (can_step_s) begin
                    pending_r   <= pending_r - PER_W'(SCROLL_STEP);
                    speed_level <= speed_level + SPEED_W'(1);
                end else begin
                    pending_r   <= pending_r;
                    speed_level <= speed_level;
                end
            end else begin
                lvl_cnt_r <= lvl_cnt_r + LVL_W'(1);
            end
        end else begin
            lvl_cnt_r <= lvl_cnt_r;
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: expected tick cycles are queued when
// stimulus is applied and matched against the DUT's ticks as they appear.
module tb_game_tick_scheduler;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_in = 1'b0;
    logic       pause_in = 1'b0;
    logic       collide_in = 1'b0;
    logic       leg_tick, scroll_tick, score_tick;
    logic [2:0] speed_level;
    logic [1:0] game_state;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    int leg_q[$];
    int scroll_q[$];
    int score_q[$];

    game_tick_scheduler dut (
        .clk_in(clk_in), .rst_n(rst_n), .start_in(start_in), .pause_in(pause_in),
        .collide_in(collide_in), .leg_tick(leg_tick), .scroll_tick(scroll_tick),
        .score_tick(score_tick), .speed_level(speed_level), .game_state(game_state)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_in);
    endtask

    // Inputs are held across exactly one rising edge; e returns that edge index.
    task automatic pulse(input logic s, input logic p, input logic c, output int e);
        start_in = s; pause_in = p; collide_in = c;
        e = cyc + 1;
        @(negedge clk_in);
        start_in = 1'b0; pause_in = 1'b0; collide_in = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"}, game_state, 0);
        chk({tag, "_leg"}, leg_tick, 0);
        chk({tag, "_scroll"}, scroll_tick, 0);
        chk({tag, "_score"}, score_tick, 0);
        chk({tag, "_speed"}, speed_level, 0);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_leg_left"}, leg_q.size(), 0);
        chk({tag, "_scroll_left"}, scroll_q.size(), 0);
        chk({tag, "_score_left"}, score_q.size(), 0);
    endtask

    // Scoreboard: every tick seen must be the next expected one for its stream.
    always @(negedge clk_in) begin
        if (mon_en) begin
            if (leg_tick !== 1'b0) begin
                if (leg_q.size() == 0) chk("leg_unexpected", cyc, 0);
                else                   chk("leg_time", cyc, leg_q.pop_front());
            end
            if (scroll_tick !== 1'b0) begin
                if (scroll_q.size() == 0) chk("scroll_unexpected", cyc, 0);
                else                      chk("scroll_time", cyc, scroll_q.pop_front());
            end
            if (score_tick !== 1'b0) begin
                if (score_q.size() == 0) chk("score_unexpected", cyc, 0);
                else                     chk("score_time", cyc, score_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tb, tc, tc_end, e;
        int t, act, lv;

        // Reset and idle: nothing ticks before start.
        repeat (3) @(negedge clk_in);
        chk_idle_outputs("reset");
        mon_en = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk_in);
        chk("idle_hold_state", game_state, 0);

        // Basic rates, ignored start in RUN, collide+pause together.
        pulse(1'b1, 1'b0, 1'b0, ta);
        chk("a_run_state", game_state, 1);
        for (int k = ta + 16; k <= ta + 512; k += 16) leg_q.push_back(k);
        for (int k = ta + 64; k <= ta + 512; k += 64) scroll_q.push_back(k);
        score_q.push_back(ta + 256);
        score_q.push_back(ta + 512);
        wait_until(ta + 199);
        pulse(1'b1, 1'b0, 1'b0, e);
        chk("a_start_ignored", game_state, 1);
        wait_until(ta + 527);
        pulse(1'b0, 1'b1, 1'b1, e);
        chk("a_collide_wins", game_state, 3);
        wait_until(ta + 600);
        chk("a_over_hold", game_state, 3);
        chk_drained("a");

        // Restart, pause window with ignored collide/start, reset mid-RUN.
        pulse(1'b1, 1'b0, 1'b0, tb);
        chk("b_run_state", game_state, 1);
        chk("b_restart_speed", speed_level, 0);
        for (int k = tb + 16; k <= tb + 96; k += 16) leg_q.push_back(k);
        for (int k = tb + 162; k <= tb + 242; k += 16) leg_q.push_back(k);
        scroll_q.push_back(tb + 64);
        scroll_q.push_back(tb + 178);
        scroll_q.push_back(tb + 242);
        wait_until(tb + 99);
        pulse(1'b0, 1'b1, 1'b0, e);
        chk("b_paused", game_state, 2);
        wait_until(tb + 119);
        pulse(1'b0, 1'b0, 1'b1, e);
        chk("b_collide_ignored", game_state, 2);
        wait_until(tb + 129);
        pulse(1'b1, 1'b0, 1'b0, e);
        chk("b_start_ignored", game_state, 2);
        wait_until(tb + 149);
        pulse(1'b0, 1'b1, 1'b0, e);
        chk("b_resumed", game_state, 1);
        wait_until(tb + 249);
        rst_n = 1'b0;
        @(negedge clk_in);
        chk_idle_outputs("b_reset");
        rst_n = 1'b1;
        wait_until(tb + 290);
        chk_drained("b");

        // Speed-up to saturation; scroll schedule from the period rules.
        pulse(1'b1, 1'b0, 1'b0, tc);
        tc_end = tc + 14600;
        for (int k = tc + 16; k < tc_end; k += 16) leg_q.push_back(k);
        for (int k = tc + 256; k < tc_end; k += 256) score_q.push_back(k);
        act = 64;
        t = tc + act;
        while (t < tc_end) begin
            scroll_q.push_back(t);
            lv = 0;
            for (int j = 1; j <= 7; j++) if (tc + 2048 * j + 2 <= t) lv = j;
            if (lv > 6) lv = 6;
            act = 64 - 8 * lv;
            t += act;
        end
        for (int j = 1; j <= 7; j++) begin
            wait_until(tc + 2048 * j);
            chk("c_speed_before", speed_level, (j - 1 > 6) ? 6 : j - 1);
            wait_until(tc + 2048 * j + 1);
            chk("c_speed_after", speed_level, (j > 6) ? 6 : j);
        end
        wait_until(tc_end - 1);
        chk("c_speed_final", speed_level, 6);
        rst_n = 1'b0;
        @(negedge clk_in);
        chk_idle_outputs("c_reset");
        rst_n = 1'b1;
        repeat (30) @(negedge clk_in);
        chk_drained("c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
